// File: rtl/simd_pkg.sv
// simd_pkg: shared opcode constants, sequencer state type and instruction
// field helpers used by simd_sequencer and its testbench.
package simd_pkg;

  localparam int OPCODE_WIDTH  = 4;
  localparam int MAX_INS_WIDTH = 64;

  localparam logic [OPCODE_WIDTH-1:0] HALT_OP = 4'hF;
  localparam logic [OPCODE_WIDTH-1:0] NOP_OP  = 4'h0;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE,
    DRAIN
  } seq_state_t;

  // The opcode occupies the top OPCODE_WIDTH bits of an ins_width-bit word;
  // callers pass the word zero-extended to MAX_INS_WIDTH.
  function automatic logic [OPCODE_WIDTH-1:0] opcode_of(
    input logic [MAX_INS_WIDTH-1:0] ins,
    input int unsigned              ins_width
  );
    return OPCODE_WIDTH'(ins >> (ins_width - OPCODE_WIDTH));
  endfunction

endpackage

// File: rtl/simd_sequencer.sv
// simd_sequencer: fetches instructions from a synchronous instruction memory
// and issues one every two cycles to the SIMD datapath. A HALT opcode, an
// abort or a PC overflow stops issue; the block then waits 2*PIPE_DEPTH
// cycles for the datapath pipeline to drain and pulses done.
// Optional build macro SIMD_SEQ_PERF_CNT_EN adds cycle_count / ins_count.
module simd_sequencer
  import simd_pkg::*;
#(
  parameter int                      INS_ADDR_WIDTH = 8,
  parameter int                      OPCODE_WIDTH   = simd_pkg::OPCODE_WIDTH,
  parameter int                      ADDR_WIDTH     = 10,
  parameter logic [OPCODE_WIDTH-1:0] HALT_OP        = simd_pkg::HALT_OP,
  parameter int                      PIPE_DEPTH     = 3
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               start,
  input  logic                               abort,
  input  logic [INS_ADDR_WIDTH-1:0]          base_pc,
  output logic [INS_ADDR_WIDTH-1:0]          imem_addr,
  input  logic [OPCODE_WIDTH+3*ADDR_WIDTH-1:0] imem_rdata,
  output logic [OPCODE_WIDTH+3*ADDR_WIDTH-1:0] ins_out,
  output logic                               ins_valid,
  output logic                               busy,
  output logic                               done,
`ifdef SIMD_SEQ_PERF_CNT_EN
  output logic [31:0]                        cycle_count,
  output logic [INS_ADDR_WIDTH:0]            ins_count,
`endif
  output logic                               err
);

  localparam int                INS_WIDTH  = OPCODE_WIDTH + 3*ADDR_WIDTH;
  localparam int                DRAIN_W    = $clog2(2*PIPE_DEPTH + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(2*PIPE_DEPTH);

  seq_state_t                 r_state, w_state_nxt;
  logic [DRAIN_W-1:0]         r_drain_cnt, w_cnt_nxt;
  logic [INS_ADDR_WIDTH-1:0]  r_pc;
  logic [INS_WIDTH-1:0]       r_ins_out;
  logic                       r_ins_valid;
  logic                       r_busy;
  logic                       r_done;
  logic                       r_err;

  logic                       w_accept;
  logic                       w_issue;
  logic                       w_pc_inc;
  logic                       w_set_err;
  logic                       w_last_drain;
  logic [OPCODE_WIDTH-1:0]    w_opcode;

  assign w_opcode = opcode_of(MAX_INS_WIDTH'(imem_rdata), INS_WIDTH);

  // State register: next state and drain count come from the decode below.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_cnt_nxt;
    end
  end

  // Next-state decode: fetch/issue cadence, HALT/abort/overflow exits, drain.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_drain_cnt;
    w_accept    = 1'b0;
    w_issue     = 1'b0;
    w_pc_inc    = 1'b0;
    w_set_err   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = FETCH;
        end
      end
      FETCH: begin
        if (abort) begin
          w_state_nxt = DRAIN;
          w_cnt_nxt   = DRAIN_LOAD;
        end else begin
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (abort || (w_opcode == HALT_OP)) begin
          w_state_nxt = DRAIN;
          w_cnt_nxt   = DRAIN_LOAD;
        end else begin
          w_issue = 1'b1;
          if (r_pc == '1) begin
            // Last address already issued: the PC must not wrap.
            w_set_err   = 1'b1;
            w_state_nxt = DRAIN;
            w_cnt_nxt   = DRAIN_LOAD;
          end else begin
            w_pc_inc    = 1'b1;
            w_state_nxt = FETCH;
          end
        end
      end
      DRAIN: begin
        w_cnt_nxt = r_drain_cnt - 1'b1;
        if (r_drain_cnt == DRAIN_W'(1)) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // done marks the final drain cycle; busy drops in that same cycle.
  assign w_last_drain = (w_state_nxt == DRAIN) && (w_cnt_nxt == DRAIN_W'(1));

  // Registered outputs: PC, issued instruction, status flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pc        <= '0;
      r_ins_out   <= '0;
      r_ins_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_pc <= base_pc;
      end else if (w_pc_inc) begin
        r_pc <= r_pc + 1'b1;
      end
      if (w_accept) begin
        r_err <= 1'b0;
      end else if (w_set_err) begin
        r_err <= 1'b1;
      end
      r_ins_valid <= w_issue;
      r_ins_out   <= w_issue ? imem_rdata : '0;
      r_busy      <= (w_state_nxt != IDLE) && !w_last_drain;
      r_done      <= w_last_drain;
    end
  end

  assign imem_addr = r_pc;
  assign ins_out   = r_ins_out;
  assign ins_valid = r_ins_valid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

`ifdef SIMD_SEQ_PERF_CNT_EN
  logic [31:0]               r_cycle_count;
  logic [INS_ADDR_WIDTH:0]   r_ins_count;

  // Performance counters: cleared on start, frozen once busy drops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cycle_count <= '0;
      r_ins_count   <= '0;
    end else if (w_accept) begin
      r_cycle_count <= '0;
      r_ins_count   <= '0;
    end else begin
      if (r_busy) begin
        r_cycle_count <= r_cycle_count + 1'b1;
      end
      if (r_ins_valid) begin
        r_ins_count <= r_ins_count + 1'b1;
      end
    end
  end

  assign cycle_count = r_cycle_count;
  assign ins_count   = r_ins_count;
`endif

endmodule

// File: tb/tb_simd_sequencer.sv
// tb_simd_sequencer: scoreboard bench. A program-level reference model turns
// memory contents, base_pc and abort timing into expected issue/done events
// (relative to the start cycle); a monitor pops and compares them whenever
// the DUT shows ins_valid or done.
module tb_simd_sequencer;
  import simd_pkg::*;

  localparam int IAW   = 8;
  localparam int OPW   = 4;
  localparam int AW    = 10;
  localparam int IW    = OPW + 3*AW;
  localparam int DW    = IW - OPW;
  localparam int PD    = 3;
  localparam int DRAIN = 2*PD;

  typedef struct {
    bit             is_done;
    int             rel;
    logic [IW-1:0]  data;
    bit             err;
  } exp_t;

  logic            clk = 1'b0;
  logic            rstn = 1'b1;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [IAW-1:0]  base_pc = '0;
  logic [IAW-1:0]  imem_addr;
  logic [IW-1:0]   imem_rdata;
  logic [IW-1:0]   ins_out;
  logic            ins_valid, busy, done, err;
`ifdef SIMD_SEQ_PERF_CNT_EN
  logic [31:0]     cycle_count;
  logic [IAW:0]    ins_count;
`endif

  simd_sequencer #(
    .INS_ADDR_WIDTH(IAW), .OPCODE_WIDTH(OPW), .ADDR_WIDTH(AW),
    .HALT_OP(HALT_OP), .PIPE_DEPTH(PD)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .base_pc(base_pc), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .ins_out(ins_out), .ins_valid(ins_valid), .busy(busy), .done(done),
`ifdef SIMD_SEQ_PERF_CNT_EN
    .cycle_count(cycle_count), .ins_count(ins_count),
`endif
    .err(err)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: data one cycle after address.
  logic [IW-1:0] mem [256];
  always @(posedge clk) imem_rdata <= mem[imem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t            exp_q[$];
  int              fq_rel[$];
  logic [IAW-1:0]  fq_addr[$];
  int              t_start = 0;
  int              n_checks = 0;
  int              n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc - t_start);
    end
  endtask

  function automatic logic [IW-1:0] rnd_ins();
    return {OPW'($urandom_range(0, 14)), DW'($urandom)};
  endfunction

  // Monitor: compare every presented issue/done against the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rstn) begin
      if (!ins_valid) check("ins_out_nop", 64'(ins_out), 64'd0);
      if (ins_valid || done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", {62'd0, ins_valid, done}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("evt_kind_done", 64'(done), 64'(e.is_done));
          check("evt_cycle", 64'(cyc - t_start), 64'(e.rel));
          if (!e.is_done) check("evt_ins_out", 64'(ins_out), 64'(e.data));
          check("evt_busy", 64'(busy), 64'(!e.is_done));
          check("evt_err", 64'(err), 64'(e.err));
        end
      end
    end
  end

  // Reference model: walks the program one instruction per two cycles.
  // The FETCH of instruction k is at relative cycle 1+2k, its ISSUE one later,
  // and the issue appears on ins_valid the cycle after that.
  task automatic model_prog(input logic [IAW-1:0] base, input int abort_rel,
                            output int done_rel, output int n_iss);
    int   pc, t;
    bit   fin, sticky;
    exp_t e;
    pc = int'(base); t = 1; fin = 0; sticky = 0; n_iss = 0; done_rel = 0;
    fq_rel.delete(); fq_addr.delete();
    while (!fin) begin
      fq_rel.push_back(t);
      fq_addr.push_back(IAW'(pc));
      if (abort_rel == t) begin
        done_rel = t + DRAIN; fin = 1;
      end else if (abort_rel == t + 1 || mem[pc][IW-1 -: OPW] == HALT_OP) begin
        done_rel = t + 1 + DRAIN; fin = 1;
      end else begin
        e.is_done = 0; e.rel = t + 2; e.data = mem[pc]; e.err = (pc == 255);
        exp_q.push_back(e);
        n_iss++;
        if (pc == 255) begin
          sticky = 1; done_rel = t + 1 + DRAIN; fin = 1;
        end else begin
          pc++; t += 2;
        end
      end
    end
    e.is_done = 1; e.rel = done_rel; e.data = '0; e.err = sticky;
    exp_q.push_back(e);
  endtask

  task automatic run_prog(input logic [IAW-1:0] base, input int abort_rel, input int start2_rel);
    int done_rel, n_iss, fr;
    logic [IAW-1:0] fa;
    model_prog(base, abort_rel, done_rel, n_iss);
    @(posedge clk); #1;
    base_pc = base; start = 1'b1; abort = (abort_rel == 0); t_start = cyc;
    for (int rel = 1; rel <= done_rel + 3; rel++) begin
      @(posedge clk); #1;
      start = (rel == start2_rel);
      abort = (rel == abort_rel);
      base_pc = IAW'($urandom);
      @(negedge clk);
      if (fq_rel.size() > 0 && fq_rel[0] == rel) begin
        fr = fq_rel.pop_front();
        fa = fq_addr.pop_front();
        check("imem_addr", 64'(imem_addr), 64'(fa));
      end
      if (rel == 1) begin
        check("busy_after_start", 64'(busy), 64'd1);
        check("err_cleared", 64'(err), 64'd0);
      end
      if (start2_rel > 0 && rel == start2_rel + 1 && rel < done_rel)
        check("busy_hold", 64'(busy), 64'd1);
      if (rel >= done_rel) check("busy_idle", 64'(busy), 64'd0);
    end
    start = 1'b0; abort = 1'b0;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
`ifdef SIMD_SEQ_PERF_CNT_EN
    check("ins_count", 64'(ins_count), 64'(n_iss));
    check("cycle_count", 64'(cycle_count), 64'(done_rel - 1));
`endif
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ins_valid"}, 64'(ins_valid), 64'd0);
    check({tag, "_ins_out"}, 64'(ins_out), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_imem_addr"}, 64'(imem_addr), 64'd0);
`ifdef SIMD_SEQ_PERF_CNT_EN
    check({tag, "_cycle_count"}, 64'(cycle_count), 64'd0);
    check({tag, "_ins_count"}, 64'(ins_count), 64'd0);
`endif
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = rnd_ins();
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int dr, ni;
    fill_mem();
    #2 rstn = 1'b0;
    #1 check_quiet("reset");
    repeat (3) @(posedge clk);
    #2 rstn = 1'b1;

    // Three instructions then HALT at 0x10.
    fill_mem();
    mem[8'h13] = {HALT_OP, DW'($urandom)};
    run_prog(8'h10, -1, -1);

    // HALT as the very first instruction.
    mem[8'h20] = {HALT_OP, DW'($urandom)};
    run_prog(8'h20, -1, -1);

    // Overflow at the top of the address space; the next start clears err.
    fill_mem();
    run_prog(8'hFE, -1, -1);
    mem[8'h13] = {HALT_OP, DW'($urandom)};
    run_prog(8'h10, -1, -1);

    // Abort the cycle after the 2nd issue; a start during drain is ignored.
    fill_mem();
    run_prog(8'h30, 6, 8);

    // start and abort together in IDLE, then abort in the first FETCH.
    run_prog(8'h10, 0, -1);
    run_prog(8'h10, 1, -1);

    // Randomized programs, some near the top address, some aborted.
    for (int k = 0; k < 24; k++) begin
      logic [IAW-1:0] b;
      int len, ar;
      b   = (k % 4 == 0) ? IAW'($urandom_range(248, 255)) : IAW'($urandom);
      len = $urandom_range(0, 6);
      fill_mem();
      if (int'(b) + len <= 255) mem[int'(b) + len] = {HALT_OP, DW'($urandom)};
      ar = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 16)) : -1;
      run_prog(b, ar, -1);
    end

    // Asynchronous reset in the middle of a program.
    fill_mem();
    model_prog(8'h40, -1, dr, ni);
    @(posedge clk); #1;
    base_pc = 8'h40; start = 1'b1; t_start = cyc;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rstn = 1'b0;
    #1 check_quiet("midreset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_after_reset_busy", 64'(busy), 64'd0);
      check("idle_after_reset_valid", 64'(ins_valid), 64'd0);
    end

    // Block still works after the reset.
    mem[8'h13] = {HALT_OP, DW'($urandom)};
    run_prog(8'h10, -1, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
